mcu: RTL and testbench
======================

# mcu

Main control unit of the encrypt/decrypt datapath. It sequences key generation, latches the requested cipher mode, and moves data from the receive FIFO through the cipher core into the transmit FIFO. It reports progress to the host through a 4-bit status word. It sits between the host-facing FIFOs/command decoder and the cipher core.

## Interface
Parameters: none.
- clk  in  1  system clock, rising edge
- n_reset  in  1  asynchronous reset; despite the name it is **active-high** (1 = reset)
- generation_done  in  1  key schedule finished (level)
- key_in  in  1  host supplied a new key (pulse)
- is_encryption_pulse  in  1  encrypt command (1-cycle pulse)
- is_decryption_pulse  in  1  decrypt command (1-cycle pulse)
- emptyRx / fullRx  in  1  receive FIFO flags
- emptyTx / fullTx  in  1  transmit FIFO flags
- data_done  in  1  cipher core finished current block (level or pulse)
- accepted  out  1  command accepted (1-cycle pulse)
- is_encrypt  out  1  latched mode, 1 = encrypt, 0 = decrypt
- read_fifo  out  1  cipher core loads block (1-cycle pulse, same cycle as rcv_deq)
- rcv_deq  out  1  dequeue receive FIFO (1-cycle pulse)
- trans_enq  out  1  enqueue result into transmit FIFO (1-cycle pulse)
- mcu_key_in  out  1  start key generation (1-cycle pulse)
- status_bits  out  4  {busy, key_needed, is_encrypt, rx_overflow}

## Operation
- Moore FSM. All outputs are decoded from the state register plus registered flags, with no combinational input-to-output paths.
- States and transitions:
  - NOKEY: wait for key_in, then go to KEY_START.
  - KEY_START: drive mcu_key_in=1, then go to KEYGEN.
  - KEYGEN: wait for generation_done, then go to READY.
  - READY: key_in goes to KEY_START. Exactly one mode pulse latches is_encrypt and goes to ACCEPT. Both mode pulses high in the same cycle are ignored.
  - ACCEPT: drive accepted=1, then go to WAIT_DATA.
  - WAIT_DATA:
    - key_in goes to KEY_START (highest priority).
    - A single mode pulse relatches the mode and goes to ACCEPT.
    - Otherwise, when !emptyRx && !fullTx, go to DEQ. Otherwise stay.
  - DEQ: drive rcv_deq=1 and read_fifo=1, then go to PROCESS.
  - PROCESS: wait for data_done, then go to ENQ. key_in and mode pulses are ignored here.
  - ENQ: drive trans_enq=1, then go to WAIT_DATA.
- busy=1 in KEY_START, KEYGEN, DEQ, PROCESS and ENQ.
- key_needed=1 in NOKEY, KEY_START and KEYGEN.
- Reset values: state NOKEY, is_encrypt=0, all pulse outputs 0, status_bits=4'b0100.
- Reset asserted mid-operation aborts immediately to NOKEY. The key is considered lost.

## Timing
- Every output pulse lasts exactly one cycle and starts the cycle after the triggering input is sampled.
  - key_in at edge N gives mcu_key_in high during cycle N+1.
  - A mode pulse at edge N gives accepted high during N+1 and is_encrypt valid from N+1.
- Minimum cost per block: WAIT_DATA→DEQ→PROCESS→ENQ is 3 cycles plus the cipher latency.
- A pulse arriving in a state that does not sample it is dropped. The host must retry.

## Configuration
- MCU_RX_OVERFLOW_EN defined:
  - status_bits[0] is a sticky flag, set on any cycle with fullRx=1.
  - Cleared by reset or by an accepted command (ACCEPT state).
- MCU_RX_OVERFLOW_EN undefined: status_bits[0] is tied to 0 and the flag register is not built.

## Structure
- Package mcu_pkg holds:
  - typedef enum logic [3:0] mcu_state_t (the nine states above)
  - localparams STAT_BUSY=3, STAT_KEYNEED=2, STAT_MODE=1, STAT_OVF=0
  - localparam STATUS_RESET=4'b0100
- Single flat module with no sub-module. The FSM and two flag registers fit comfortably in one block.

## Test plan
- Reset for 2 cycles, release, and hold idle inputs → status_bits=4'b0100, all pulses 0, is_encrypt=0.
- key_in pulse → mcu_key_in one cycle later, status 4'b1100. Then generation_done=1 → status 4'b0000.
- From READY, is_encryption_pulse → accepted for one cycle, is_encrypt=1, status 4'b0010. Both pulses together → no accepted and state unchanged.
- Mode accepted, emptyRx=0, fullTx=0 → rcv_deq and read_fifo for one cycle, busy=1. data_done → trans_enq for one cycle, then a new DEQ if emptyRx is still 0. fullTx=1 → stalls in WAIT_DATA with no rcv_deq.
- With MCU_RX_OVERFLOW_EN, fullRx for one cycle → status_bits[0]=1 persists until the next accepted command. Reset asserted during PROCESS → status 4'b0100 immediately.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and constants for the main control unit of the cipher datapath.
package mcu_pkg;

    typedef enum logic [3:0] {
        NOKEY     = 4'd0,
        KEY_START = 4'd1,
        KEYGEN    = 4'd2,
        READY     = 4'd3,
        ACCEPT    = 4'd4,
        WAIT_DATA = 4'd5,
        DEQ       = 4'd6,
        PROCESS   = 4'd7,
        ENQ       = 4'd8
    } mcu_state_t;

    localparam int STAT_BUSY    = 3;
    localparam int STAT_KEYNEED = 2;
    localparam int STAT_MODE    = 1;
    localparam int STAT_OVF     = 0;

    localparam logic [3:0] STATUS_RESET = 4'b0100;

endpackage

// File: rtl/mcu.sv
// Main control unit: key generation sequencing, mode latch and RX->cipher->TX block flow.
// Optional sticky RX overflow flag on status_bits[0] when MCU_RX_OVERFLOW_EN is defined.
module mcu
    import mcu_pkg::*;
(
    input  logic       clk,
    input  logic       n_reset,
    input  logic       generation_done,
    input  logic       key_in,
    input  logic       is_encryption_pulse,
    input  logic       is_decryption_pulse,
    input  logic       emptyRx,
    input  logic       fullRx,
    input  logic       emptyTx,
    input  logic       fullTx,
    input  logic       data_done,
    output logic       accepted,
    output logic       is_encrypt,
    output logic       read_fifo,
    output logic       rcv_deq,
    output logic       trans_enq,
    output logic       mcu_key_in,
    output logic [3:0] status_bits
);

    mcu_state_t state_q, state_d;
    logic       is_encrypt_q, is_encrypt_d;
    logic       one_mode;
    logic       ovf;

    // Simultaneous encrypt/decrypt commands are contradictory and ignored.
    assign one_mode = is_encryption_pulse ^ is_decryption_pulse;

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            state_q      <= NOKEY;
            is_encrypt_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_encrypt_q <= is_encrypt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        is_encrypt_d = is_encrypt_q;
        unique case (state_q)
            NOKEY:     if (key_in) state_d = KEY_START;
            KEY_START: state_d = KEYGEN;
            KEYGEN:    if (generation_done) state_d = READY;
            READY: begin
                if (key_in) begin
                    state_d = KEY_START;
                end else if (one_mode) begin
                    is_encrypt_d = is_encryption_pulse;
                    state_d      = ACCEPT;
                end
            end
            ACCEPT:    state_d = WAIT_DATA;
            WAIT_DATA: begin
                if (key_in) begin
                    state_d = KEY_START;
                end else if (one_mode) begin
                    is_encrypt_d = is_encryption_pulse;
                    state_d      = ACCEPT;
                end else if (!emptyRx && !fullTx) begin
                    state_d = DEQ;
                end
            end
            DEQ:       state_d = PROCESS;
            PROCESS:   if (data_done) state_d = ENQ;
            ENQ:       state_d = WAIT_DATA;
            default:   state_d = NOKEY;
        endcase
    end

`ifdef MCU_RX_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic unused_ok;

    // A full RX in the same cycle as ACCEPT still counts as a fresh overflow.
    assign ovf_d = (ovf_q && (state_q != ACCEPT)) || fullRx;

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    assign ovf       = ovf_q;
    assign unused_ok = emptyTx;
`else
    logic unused_ok;
    assign ovf       = 1'b0;
    assign unused_ok = ^{emptyTx, fullRx};
`endif

    assign accepted   = (state_q == ACCEPT);
    assign mcu_key_in = (state_q == KEY_START);
    assign rcv_deq    = (state_q == DEQ);
    assign read_fifo  = (state_q == DEQ);
    assign trans_enq  = (state_q == ENQ);
    assign is_encrypt = is_encrypt_q;

    assign status_bits[STAT_BUSY]    = (state_q == KEY_START) || (state_q == KEYGEN) ||
                                       (state_q == DEQ) || (state_q == PROCESS) ||
                                       (state_q == ENQ);
    assign status_bits[STAT_KEYNEED] = (state_q == NOKEY) || (state_q == KEY_START) ||
                                       (state_q == KEYGEN);
    assign status_bits[STAT_MODE]    = is_encrypt_q;
    assign status_bits[STAT_OVF]     = ovf;

endmodule

// File: tb/tb_mcu.sv
// Scoreboard bench for mcu: stimulus queues expected pulse events, a monitor pops and compares.
module tb_mcu;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       generation_done, key_in, is_encryption_pulse, is_decryption_pulse;
    logic       emptyRx, fullRx, emptyTx, fullTx, data_done;
    logic       accepted, is_encrypt, read_fifo, rcv_deq, trans_enq, mcu_key_in;
    logic [3:0] status_bits;

    typedef struct packed {
        logic [4:0] pulses;   // {accepted, read_fifo, rcv_deq, trans_enq, mcu_key_in}
        logic [3:0] status;
    } exp_t;

    localparam logic [4:0] P_ACC = 5'b10000;
    localparam logic [4:0] P_DEQ = 5'b01100;
    localparam logic [4:0] P_ENQ = 5'b00010;
    localparam logic [4:0] P_KEY = 5'b00001;

`ifdef MCU_RX_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mcu dut (
        .clk                 (clk),
        .n_reset             (n_reset),
        .generation_done     (generation_done),
        .key_in              (key_in),
        .is_encryption_pulse (is_encryption_pulse),
        .is_decryption_pulse (is_decryption_pulse),
        .emptyRx             (emptyRx),
        .fullRx              (fullRx),
        .emptyTx             (emptyTx),
        .fullTx              (fullTx),
        .data_done           (data_done),
        .accepted            (accepted),
        .is_encrypt          (is_encrypt),
        .read_fifo           (read_fifo),
        .rcv_deq             (rcv_deq),
        .trans_enq           (trans_enq),
        .mcu_key_in          (mcu_key_in),
        .status_bits         (status_bits)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with a pulse output must match the next queued event.
    always @(negedge clk) begin
        logic [4:0] p;
        exp_t       e;
        p = {accepted, read_fifo, rcv_deq, trans_enq, mcu_key_in};
        if (!n_reset && (p != 5'b0)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: got pulses=%b status=%b, required none", p, status_bits);
            end else begin
                e = sb.pop_front();
                if (p != e.pulses || status_bits != e.status) begin
                    failures++;
                    $display("FAIL pulse_event: got pulses=%b status=%b, required pulses=%b status=%b",
                             p, status_bits, e.pulses, e.status);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [4:0] p, input logic [3:0] s);
        exp_t e;
        e.pulses = p;
        e.status = s;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] pulses_now();
        return {3'b0, accepted, read_fifo, rcv_deq, trans_enq, mcu_key_in};
    endfunction

    initial begin
        n_reset = 1'b1;
        generation_done = 0; key_in = 0; is_encryption_pulse = 0; is_decryption_pulse = 0;
        emptyRx = 1; fullRx = 0; emptyTx = 1; fullTx = 0; data_done = 0;
        repeat (2) step();
        n_reset = 1'b0;
        step();
        chk("reset_status", {4'b0, status_bits}, 8'h04);
        chk("reset_pulses", pulses_now(), 8'h00);
        chk("reset_mode", {7'b0, is_encrypt}, 8'h00);

        // Key generation
        key_in = 1; expect_ev(P_KEY, 4'b1100);
        step();                         // KEY_START
        key_in = 0;
        step();                         // KEYGEN
        chk("keygen_status", {4'b0, status_bits}, 8'h0C);
        step();
        chk("keygen_hold", {4'b0, status_bits}, 8'h0C);
        generation_done = 1;
        step();                         // READY
        generation_done = 0;
        chk("ready_status", {4'b0, status_bits}, 8'h00);

        // Both mode pulses together: ignored
        is_encryption_pulse = 1; is_decryption_pulse = 1;
        step();
        is_encryption_pulse = 0; is_decryption_pulse = 0;
        chk("both_pulses_status", {4'b0, status_bits}, 8'h00);
        step();
        chk("both_pulses_mode", {7'b0, is_encrypt}, 8'h00);

        // Encrypt command
        is_encryption_pulse = 1; expect_ev(P_ACC, 4'b0010);
        step();                         // ACCEPT
        is_encryption_pulse = 0;
        chk("enc_mode", {7'b0, is_encrypt}, 8'h01);
        step();                         // WAIT_DATA, RX empty
        step();
        chk("wait_empty_status", {4'b0, status_bits}, 8'h02);

        // Two blocks back to back
        emptyRx = 0; expect_ev(P_DEQ, 4'b1010);
        step();                         // DEQ
        step();                         // PROCESS
        key_in = 1; is_decryption_pulse = 1;
        step();                         // ignored in PROCESS
        key_in = 0; is_decryption_pulse = 0;
        step();
        chk("process_status", {4'b0, status_bits}, 8'h0A);
        data_done = 1; expect_ev(P_ENQ, 4'b1010); expect_ev(P_DEQ, 4'b1010);
        step();                         // ENQ
        data_done = 0;
        step();                         // WAIT_DATA
        chk("wait_between_blocks", {4'b0, status_bits}, 8'h02);
        step();                         // DEQ
        step();                         // PROCESS
        fullTx = 1;
        data_done = 1; expect_ev(P_ENQ, 4'b1010);
        step();                         // ENQ
        data_done = 0;
        step();                         // WAIT_DATA, TX full
        repeat (3) step();
        chk("stall_fulltx", {4'b0, status_bits}, 8'h02);

        // Decrypt relatch from WAIT_DATA
        is_decryption_pulse = 1; expect_ev(P_ACC, 4'b0000);
        step();
        is_decryption_pulse = 0;
        chk("dec_mode", {7'b0, is_encrypt}, 8'h00);
        step();                         // WAIT_DATA

        // Rekey from WAIT_DATA
        key_in = 1; expect_ev(P_KEY, 4'b1100);
        step();
        key_in = 0;
        step();
        generation_done = 1;
        step();                         // READY
        generation_done = 0;

        // RX overflow flag
        fullRx = 1;
        step();
        fullRx = 0;
        step();
        chk("ovf_set", {7'b0, status_bits[0]}, {7'b0, OVF_EXP});
        step();
        chk("ovf_sticky", {7'b0, status_bits[0]}, {7'b0, OVF_EXP});
        is_encryption_pulse = 1; expect_ev(P_ACC, {3'b001, OVF_EXP});
        step();                         // ACCEPT
        is_encryption_pulse = 0;
        fullTx = 0; expect_ev(P_DEQ, 4'b1010);
        step();                         // WAIT_DATA
        chk("ovf_cleared", {4'b0, status_bits}, 8'h02);
        step();                         // DEQ
        step();                         // PROCESS

        // Reset mid-block
        n_reset = 1;
        #1;
        chk("abort_status", {4'b0, status_bits}, 8'h04);
        chk("abort_mode", {7'b0, is_encrypt}, 8'h00);
        step();
        n_reset = 0;
        emptyRx = 1;
        repeat (3) step();
        chk("post_abort_status", {4'b0, status_bits}, 8'h04);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses: got %0d outstanding, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
